uart_transmitter: RTL
=====================

# uart_transmitter

Transmit path of the UART core: a byte FIFO feeding a serializer that drives the serial output line. It sits directly downstream of the WISHBONE interface stage. It consumes that stage's registered write-enable together with the write data when the transmit holding register is addressed, and frames each byte per the line-control settings. It reports FIFO status back to the register and interrupt logic.

## Interface

**Parameters**
- `FIFO_DEPTH`, default 16: transmit FIFO entries (power of two, ≥ 2).
- `CNT_W`, default 5: width of `tf_count`; equals log2(`FIFO_DEPTH`) + 1.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: core clock. One clock; reset is synchronous and active-high.
- `wb_rst_i`, in, 1: synchronous active-high reset.
- `we_i`, in, 1: one-cycle push strobe, already decoded for the transmit holding register.
- `dat_i`, in, 8: byte to push; sampled when `we_i`=1.
- `lcr`, in, 7: line control.
  - [1:0] data bits: 0→5, 1→6, 2→7, 3→8.
  - [2]: 2 stop bits when set.
  - [3]: parity enable.
  - [4]: even parity.
  - [5]: stick parity.
  - [6]: break.
- `enable`, in, 1: baud tick at 16× bit rate, one clock wide.
- `tx_reset`, in, 1: FIFO flush pulse.
- `stx_o`, out, 1: serial output, idle high.
- `tf_count`, out, `CNT_W`: FIFO occupancy.
- `tf_full`, out, 1: FIFO full.
- `thre_o`, out, 1: FIFO empty (holding register empty).
- `temt_o`, out, 1: FIFO empty and serializer idle.
- `tf_overrun`, out, 1: one-cycle pulse when a push is dropped.

## Operation

**FIFO**
- Circular buffer with read/write pointers that wrap modulo `FIFO_DEPTH`.
- Push occurs when `we_i`=1 and not full.
- A push while full is dropped, the contents are unchanged, and `tf_overrun` pulses.
- A pop is requested only by the serializer.
- Simultaneous push and pop: allowed at any occupancy, including full. Count is unchanged and both operations take effect.
- `tx_reset` clears the pointers and count. It has priority over a same-cycle push, which is discarded with no overrun pulse.
- `tx_reset` does not abort a frame in progress.

**Serializer FSM**
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- A 4-bit tick counter advances on `enable`. Each state lasts exactly 16 `enable` ticks.
- IDLE: `stx_o`=1. On an `enable` tick with FIFO non-empty:
  - pop the head into the shift register;
  - latch `lcr[5:0]` for the whole frame;
  - go to START.
- START: `stx_o`=0.
- DATA: `stx_o` = shift register bit 0, LSB first. Shift every 16 ticks; count N = 5..8 bits.
- PARITY (entered only if the latched parity enable is set), value computed over the N data bits:
  - stick parity: bit = NOT even (so even → 0, odd → 1);
  - otherwise even parity → XOR of data bits;
  - otherwise odd parity → XNOR of data bits.
- STOP1: `stx_o`=1. Then go to STOP2 if 2 stop bits are selected, else IDLE.
- STOP2: `stx_o`=1, then IDLE.
- From IDLE, a new frame may start on the first `enable` tick after return (back-to-back frames).
- Break: while `lcr[6]`=1, `stx_o` is forced 0 and the FSM keeps running unchanged.

**Status**
- `thre_o` = (count==0).
- `temt_o` = `thre_o` AND state==IDLE.
- `tf_full` = (count==`FIFO_DEPTH`).

## Timing

**Reset values** (next `clk` edge with `wb_rst_i`=1)
- `stx_o`=1, `tf_count`=0, `tf_full`=0, `thre_o`=1, `temt_o`=1, `tf_overrun`=0.
- FSM returns to IDLE, including from mid-frame; the line goes high the cycle after reset.

**Latencies**
- `we_i` at edge N: `tf_count`, `thre_o` and `tf_full` update at N+1.
- Pop on an `enable` tick at edge M: `stx_o`=0 from M+1, and `tf_count` decrements at M+1.
- The frame length in ticks is 16 × (1 + N + P + S), where P is 0/1 for parity and S is 1/2 stop bits.
- All outputs are registered except `thre_o`, `temt_o` and `tf_full`, which decode registered state.
- `tf_overrun` is registered and high for exactly one cycle per dropped push.
- `lcr` changes mid-frame do not affect the current frame, except break, which takes effect the next cycle.
- `enable` absent: the FSM holds state indefinitely.

## Test plan

1. **8N1 frame.** `lcr`=0x03, `enable` every cycle, push 0xA5. Expect `stx_o` = 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles. Then `temt_o`=1.
2. **Parity, 2 stop bits.** `lcr`=0x1E (7 data bits, even parity, 2 stop), push 0x37. Expect start; data 1,1,1,0,1,1,0; parity 1; stop 1,1. Repeat with `lcr`=0x2B (stick): parity bit 1.
3. **Fill to overflow.** Push 17 bytes with `enable`=0. Expect `tf_count`=16 and `tf_full`=1, one `tf_overrun` pulse on the 17th push, and FIFO contents bytes 1–16.
4. **Push and pop together at full.** With the FIFO full, push in the same cycle as a serializer pop. Expect `tf_count` to stay 16, no overrun, and the new byte transmitted last.
5. **Mid-frame interruptions.**
   - Assert `wb_rst_i` during DATA: `stx_o`=1 next cycle and `tf_count`=0.
   - Separately, assert `tx_reset` mid-frame: the current frame completes and no further frames follow.
6. **Break.** Set `lcr[6]`=1 mid-frame: `stx_o`=0 next cycle and `tf_count` keeps decrementing as frames complete. Clear it: the line resumes on the correct bit.

Source files
------------

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART transmit path: byte FIFO feeding a 16x-oversampled frame serializer
module uart_transmitter #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             wb_rst_i,
    input  logic             we_i,
    input  logic [7:0]       dat_i,
    input  logic [6:0]       lcr,
    input  logic             enable,
    input  logic             tx_reset,
    output logic             stx_o,
    output logic [CNT_W-1:0] tf_count,
    output logic             tf_full,
    output logic             thre_o,
    output logic             temt_o,
    output logic             tf_overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overrun;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_tick;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic [3:0]       r_lcr;
    logic             r_par;
    logic             r_stx;
    logic             w_line_nxt;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_tick_end;
    logic [7:0]       w_head;
    logic [7:0]       w_mask;
    logic             w_data_xor;
    logic             w_par_calc;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_head     = r_mem[r_rd_ptr];
    assign w_tick_end = enable && (r_tick == 4'hF);

    // A flush wins over a pop in the same cycle, so a flushed FIFO never launches a frame.
    assign w_pop  = (r_state == S_IDLE) && enable && !w_empty && !tx_reset;
    assign w_push = we_i && (!w_full || w_pop) && !tx_reset;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (wb_rst_i || tx_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= we_i && w_full && !w_pop && !tx_reset;
        end
    end

    always_comb begin
        w_mask = 8'hFF;
        case (lcr[1:0])
            2'd0:    w_mask = 8'h1F;
            2'd1:    w_mask = 8'h3F;
            2'd2:    w_mask = 8'h7F;
            default: w_mask = 8'hFF;
        endcase
    end

    assign w_data_xor = ^(w_head & w_mask);
    assign w_par_calc = lcr[5] ? ~lcr[4] : (lcr[4] ? w_data_xor : ~w_data_xor);

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_tick_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick_end && (r_bit_idx == {1'b1, r_lcr[1:0]})) begin
                    w_state_nxt = r_lcr[3] ? S_PARITY : S_STOP1;
                end
            end
            S_PARITY: begin
                if (w_tick_end) begin
                    w_state_nxt = S_STOP1;
                end
            end
            S_STOP1: begin
                if (w_tick_end) begin
                    w_state_nxt = r_lcr[2] ? S_STOP2 : S_IDLE;
                end
            end
            S_STOP2: begin
                if (w_tick_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The line is registered, so its next value is decoded from the next state and shift contents.
    always_comb begin
        w_shift_nxt = r_shift;
        if (w_pop) begin
            w_shift_nxt = w_head;
        end else if ((r_state == S_DATA) && w_tick_end) begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
        end

        w_line_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_line_nxt = 1'b0;
            S_DATA:   w_line_nxt = w_shift_nxt[0];
            S_PARITY: w_line_nxt = r_par;
            default:  w_line_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            r_tick    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_lcr     <= '0;
            r_par     <= 1'b0;
            r_stx     <= 1'b1;
        end else begin
            r_shift <= w_shift_nxt;
            r_stx   <= w_line_nxt & ~lcr[6];
            if (w_pop) begin
                r_tick    <= '0;
                r_bit_idx <= '0;
                r_lcr     <= lcr[3:0];
                r_par     <= w_par_calc;
            end else if (enable && (r_state != S_IDLE)) begin
                r_tick <= r_tick + 4'd1;
                if ((r_state == S_DATA) && (r_tick == 4'hF)) begin
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
            end
        end
    end

    assign stx_o      = r_stx;
    assign tf_count   = r_count;
    assign tf_full    = w_full;
    assign thre_o     = w_empty;
    assign temt_o     = w_empty && (r_state == S_IDLE);
    assign tf_overrun = r_overrun;

endmodule
